// File: rtl/hough_stage_scheduler.sv
// hough_stage_scheduler
// Shares one Hough transform pipeline stage between the live camera path
// (source 0) and the test-pattern/replay path (source 1). Round-robin
// arbitration, a registered mux select, a stage request/acknowledge handshake,
// a completed-frame counter and a stage-hang timeout.
// Optional feature: define HOUGH_SCHED_LATENCY_EN to capture the number of
// GRANT cycles spent waiting for the stage acknowledge into o_last_latency.
// Without the macro o_last_latency is tied to zero.
module hough_stage_scheduler #(
   parameter int COUNT_BITS     = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_enable,
   input  logic                  i_req0,
   input  logic                  i_req1,
   output logic                  o_ack0,
   output logic                  o_ack1,
   output logic                  o_sel,
   output logic                  o_stage_req,
   input  logic                  i_stage_ack,
   output logic                  o_busy,
   output logic                  o_err_pulse,
   output logic [COUNT_BITS-1:0] o_frame_count,
   output logic [COUNT_BITS-1:0] o_last_latency
);

   // Timeout counter only has to reach TIMEOUT_CYCLES-1.
   localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
   localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic                  r_sel;
   logic                  w_sel_next;
   logic                  r_last_grant;
   logic                  w_last_grant_next;
   logic                  r_ack0;
   logic                  w_ack0_next;
   logic                  r_ack1;
   logic                  w_ack1_next;
   logic                  r_err;
   logic                  w_err_next;
   logic [TW-1:0]         r_to_cnt;
   logic [TW-1:0]         w_to_cnt_next;
   logic [COUNT_BITS-1:0] r_frame_count;
   logic [COUNT_BITS-1:0] w_frame_count_next;

   logic                  w_any_req;
   logic                  w_winner;
   logic                  w_grant;

   // Round-robin pick: a lone requester wins; on a tie the source that was
   // not served last wins. Reset leaves r_last_grant=1 so source 0 wins first.
   assign w_any_req = i_req0 | i_req1;
   assign w_winner  = (i_req0 & i_req1) ? ~r_last_grant : i_req1;
   assign w_grant   = (r_state == S_IDLE) && i_enable && w_any_req;

   // State and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_sel         <= 1'b0;
         r_last_grant  <= 1'b1;
         r_ack0        <= 1'b0;
         r_ack1        <= 1'b0;
         r_err         <= 1'b0;
         r_to_cnt      <= '0;
         r_frame_count <= '0;
      end else begin
         r_state       <= w_state_next;
         r_sel         <= w_sel_next;
         r_last_grant  <= w_last_grant_next;
         r_ack0        <= w_ack0_next;
         r_ack1        <= w_ack1_next;
         r_err         <= w_err_next;
         r_to_cnt      <= w_to_cnt_next;
         r_frame_count <= w_frame_count_next;
      end
   end

   // Next-state and next-output decode; pulses default low every cycle
   always_comb begin
      w_state_next       = r_state;
      w_sel_next         = r_sel;
      w_last_grant_next  = r_last_grant;
      w_ack0_next        = 1'b0;
      w_ack1_next        = 1'b0;
      w_err_next         = 1'b0;
      w_to_cnt_next      = r_to_cnt;
      w_frame_count_next = r_frame_count;

      case (r_state)
         S_IDLE: begin
            // Enable only gates new grants; an in-flight frame always finishes.
            if (w_grant) begin
               w_state_next  = S_GRANT;
               w_sel_next    = w_winner;
               w_to_cnt_next = '0;
            end
         end

         S_GRANT: begin
            // Ack takes priority over the timeout on the same cycle, so an
            // Ack pulse and ErrPulse can never coincide.
            if (i_stage_ack) begin
               w_state_next      = S_HOLD;
               w_ack0_next       = ~r_sel;
               w_ack1_next       = r_sel;
               w_last_grant_next = r_sel;
            end else if (TO_EN && (r_to_cnt == TO_LAST)) begin
               w_state_next      = S_IDLE;
               w_err_next        = 1'b1;
               w_last_grant_next = r_sel;
            end else if (TO_EN) begin
               w_to_cnt_next = r_to_cnt + TW'(1);
            end
         end

         S_HOLD: begin
            // Frame only counts once the stage has released its acknowledge.
            if (!i_stage_ack) begin
               w_state_next       = S_IDLE;
               w_frame_count_next = r_frame_count + COUNT_BITS'(1);
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

`ifdef HOUGH_SCHED_LATENCY_EN
   logic [COUNT_BITS-1:0] r_lat_cnt;
   logic [COUNT_BITS-1:0] r_last_latency;

   // Count GRANT cycles before the stage ack is sampled; capture on ack only
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_lat_cnt      <= '0;
         r_last_latency <= '0;
      end else if (w_grant) begin
         r_lat_cnt <= '0;
      end else if (r_state == S_GRANT) begin
         if (i_stage_ack) begin
            r_last_latency <= r_lat_cnt;
         end else if (r_lat_cnt != '1) begin
            r_lat_cnt <= r_lat_cnt + COUNT_BITS'(1);
         end
      end
   end

   assign o_last_latency = r_last_latency;
`else
   assign o_last_latency = '0;
`endif

   assign o_ack0        = r_ack0;
   assign o_ack1        = r_ack1;
   assign o_sel         = r_sel;
   assign o_err_pulse   = r_err;
   assign o_frame_count = r_frame_count;
   assign o_stage_req   = (r_state == S_GRANT);
   assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_hough_stage_scheduler.sv
// Testbench for hough_stage_scheduler: frame-level reference model
// (round-robin owner, frame count, last latency) with a behavioural stage
// that acknowledges after a chosen number of GRANT cycles.
module tb_hough_stage_scheduler;

   localparam int CB = 4;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_enable = 1'b0;
   logic          i_req0 = 1'b0;
   logic          i_req1 = 1'b0;
   logic          i_stage_ack = 1'b0;
   logic          o_ack0, o_ack1, o_sel, o_stage_req, o_busy, o_err_pulse;
   logic [CB-1:0] o_frame_count, o_last_latency;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   int m_last   = 1;
   int m_frames = 0;
   int m_lat    = 0;

   hough_stage_scheduler #(
      .COUNT_BITS     (CB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clk          (clk),
      .i_reset        (i_reset),
      .i_enable       (i_enable),
      .i_req0         (i_req0),
      .i_req1         (i_req1),
      .o_ack0         (o_ack0),
      .o_ack1         (o_ack1),
      .o_sel          (o_sel),
      .o_stage_req    (o_stage_req),
      .i_stage_ack    (i_stage_ack),
      .o_busy         (o_busy),
      .o_err_pulse    (o_err_pulse),
      .o_frame_count  (o_frame_count),
      .o_last_latency (o_last_latency)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Inputs are driven and outputs sampled on the falling edge
   task automatic tick;
      @(negedge clk);
   endtask

   function automatic int exp_latency();
`ifdef HOUGH_SCHED_LATENCY_EN
      return m_lat;
`else
      return 0;
`endif
   endfunction

   function automatic logic [31:0] all_outputs();
      return {18'd0, o_ack0, o_ack1, o_sel, o_stage_req, o_busy, o_err_pulse, o_frame_count, o_last_latency};
   endfunction

   // One frame: request pattern, ack delay in GRANT cycles (>= TO means the
   // stage never answers), extra HOLD cycles, optional reset during HOLD.
   task automatic run_frame(input bit r0, input bit r1, input int delay, input int hold, input bit rst_in_hold);
      int exp_w;
      int wait_n;
      int evt_k;
      int a0;
      int a1;
      int er;
      bit timeout;
      exp_w   = (r0 && r1) ? (1 - m_last) : int'(r1);
      timeout = (delay >= TO);
      i_enable    = 1'b1;
      i_req0      = r0;
      i_req1      = r1;
      i_stage_ack = (delay == 0);
      wait_n = 0;
      do begin
         tick;
         wait_n++;
      end while (!o_stage_req && wait_n < 10);
      check("req_to_grant", wait_n, 1);
      if (!o_stage_req) begin
         i_req0 = 1'b0;
         i_req1 = 1'b0;
         i_stage_ack = 1'b0;
         return;
      end
      check("sel", o_sel, exp_w);
      check("busy_grant", o_busy, 1);
      a0 = o_ack0;
      a1 = o_ack1;
      er = o_err_pulse;
      // Enable and requests have no effect while the frame is in flight
      i_enable = 1'($urandom_range(0, 1));
      i_req0   = 1'($urandom_range(0, 1));
      i_req1   = 1'($urandom_range(0, 1));
      evt_k = 0;
      for (int k = 1; k <= TO + 4; k++) begin
         tick;
         a0 += o_ack0;
         a1 += o_ack1;
         er += o_err_pulse;
         if (o_ack0 || o_ack1 || o_err_pulse || !o_stage_req) begin
            evt_k = k;
            break;
         end
         i_stage_ack = (k >= delay);
      end
      check("event_cycle", evt_k, timeout ? TO : delay + 1);
      check("stage_req_low", o_stage_req, 0);
      check("sel_stable", o_sel, exp_w);
      i_req0 = 1'b0;
      i_req1 = 1'b0;
      m_last = exp_w;
      if (timeout) begin
         check("err_pulse", o_err_pulse, 1);
         check("busy_after_abort", o_busy, 0);
         i_stage_ack = 1'b0;
         tick;
         a0 += o_ack0;
         a1 += o_ack1;
         er += o_err_pulse;
         check("err_count", er, 1);
         check("ack_count_abort", a0 + a1, 0);
         check("frames_after_abort", o_frame_count, m_frames);
         check("latency_after_abort", o_last_latency, exp_latency());
         $display("frame src=%0d delay=%0d -> timeout frames=%0d", exp_w, delay, m_frames);
         return;
      end
      m_lat = delay;
      check("latency", o_last_latency, exp_latency());
      if (rst_in_hold) begin
         i_reset = 1'b1;
         tick;
         check("reset_in_hold_outputs", all_outputs(), 0);
         i_reset = 1'b0;
         i_stage_ack = 1'b0;
         m_last = 1;
         m_frames = 0;
         m_lat = 0;
         tick;
         check("after_reset_outputs", all_outputs(), 0);
         $display("frame src=%0d delay=%0d -> reset during hold", exp_w, delay);
         return;
      end
      for (int h = 0; h < hold; h++) begin
         tick;
         a0 += o_ack0;
         a1 += o_ack1;
         er += o_err_pulse;
      end
      check("busy_hold", o_busy, 1);
      i_stage_ack = 1'b0;
      tick;
      a0 += o_ack0;
      a1 += o_ack1;
      er += o_err_pulse;
      m_frames = (m_frames + 1) % (1 << CB);
      check("busy_after_drop", o_busy, 0);
      check("frame_count", o_frame_count, m_frames);
      check("ack0_count", a0, (exp_w == 0) ? 1 : 0);
      check("ack1_count", a1, (exp_w == 1) ? 1 : 0);
      check("err_count_ok", er, 0);
      $display("frame src=%0d delay=%0d hold=%0d -> done frames=%0d lat=%0d",
               exp_w, delay, hold, m_frames, o_last_latency);
   endtask

   initial begin
      int hi;
      int rp;
      int dly;
      // Reset state
      repeat (3) tick;
      check("reset_outputs", all_outputs(), 0);
      i_reset = 1'b0;
      tick;
      check("idle_outputs", all_outputs(), 0);

      // Single camera request, stage acks after 2 GRANT cycles
      run_frame(1'b1, 1'b0, 2, 1, 1'b0);

      // Stage hang on source 1: abort after TO cycles
      run_frame(1'b0, 1'b1, TO + 3, 0, 1'b0);

      // Both requesting, immediate ack: alternates starting with source 0
      for (int f = 0; f < 4; f++) run_frame(1'b1, 1'b1, 0, 0, 1'b0);

      // Enable low blocks grants entirely
      i_enable = 1'b0;
      i_req0   = 1'b1;
      i_req1   = 1'b0;
      hi = 0;
      for (int c = 0; c < 20; c++) begin
         tick;
         hi += (o_stage_req | o_busy);
      end
      check("enable_low_blocks", hi, 0);
      run_frame(1'b1, 1'b0, 1, 0, 1'b0);

      // Reset while holding, then a normal replay frame
      run_frame(1'b1, 1'b1, 1, 2, 1'b1);
      run_frame(1'b0, 1'b1, 3, 0, 1'b0);

      // Randomized traffic; completes well over 16 frames so the count wraps
      for (int f = 0; f < 40; f++) begin
         rp  = $urandom_range(1, 3);
         dly = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 6));
         run_frame(rp[0], rp[1], dly, $urandom_range(0, 3), 1'b0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
